mem_access_arbiter: RTL and testbench

Sequences and shares the simulator's single byte-wide memory port (8-bit data, 16-bit address) between the instruction-fetch requester and the data read/write requester of the PDP-11 core. Each 16-bit word access becomes two little-endian byte cycles: low byte at the even address, high byte at address+1. Byte accesses take one cycle. Odd-address word accesses are rejected with an error and never reach memory. The block sits between the CPU execute/decode logic and the memory model.

---
 rtl/mem_access_arbiter_pkg.sv | 38 +++
 rtl/mem_access_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_arbiter_pkg.sv
// Shared types for the byte-wide memory port arbiter: address/data types,
// access size and trace codes, and the arbiter state and owner encodings.
package mem_access_arbiter_pkg;

    typedef logic [15:0] mem_addr_t;
    typedef logic [7:0]  mem_data_t;
    typedef logic [15:0] word_t;

    typedef enum logic {
        WORD_OP = 1'b0,
        BYTE_OP = 1'b1
    } op_size;

    typedef enum logic [1:0] {
        MEM_DATA_READ  = 2'd0,
        MEM_DATA_WRITE = 2'd1,
        MEM_FETCH      = 2'd2
    } mem_access_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_LO,
        ARB_HI,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } arb_owner_t;

    function automatic mem_access_t access_code(input arb_owner_t owner, input logic we);
        if (owner == OWN_FETCH)
            return MEM_FETCH;
        return we ? MEM_DATA_WRITE : MEM_DATA_READ;
    endfunction

endpackage

// File: rtl/mem_access_arbiter.sv
// Shares one byte-wide memory port between instruction fetch and data access,
// splitting words into two little-endian byte cycles. Optional MEM_TRACE_EN.
//
// state     | meaning
// ARB_IDLE  | arbitrate pending requests, latch the winner's fields
// ARB_LO    | byte cycle at addr (low byte / the only byte)
// ARB_HI    | byte cycle at addr+1 (high byte of a word)
// ARB_RESP  | done pulse to the owner; requests not sampled
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int DATA_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_done,
    output logic [15:0] if_rdata,
    output logic        if_err,
    input  logic        dt_req,
    input  logic        dt_we,
    input  logic        dt_sz,
    input  logic [15:0] dt_addr,
    input  logic [15:0] dt_wdata,
    output logic        dt_done,
    output logic [15:0] dt_rdata,
    output logic        dt_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    arb_state_t state_q, state_d;
    arb_owner_t owner_q;
    mem_addr_t  addr_q;
    word_t      wdata_q;
    op_size     sz_q;
    logic       we_q;
    logic       err_q;
    mem_data_t  rdata_lo_q;

    logic       grant_data, grant_fetch, odd_word;
    op_size     req_sz;
    mem_addr_t  req_addr;

    logic       resp_fire;
    arb_owner_t resp_owner;
    word_t      resp_rdata;
    logic       resp_err;

    assign grant_data  = dt_req && ((DATA_FIRST != 0) || !if_req);
    assign grant_fetch = if_req && !grant_data;
    assign req_sz      = grant_data ? op_size'(dt_sz) : WORD_OP;
    assign req_addr    = grant_data ? dt_addr : if_addr;
    assign odd_word    = (req_sz == WORD_OP) && req_addr[0];

    always_ff @(posedge clk) begin
        if (!reset_n)
            state_q <= ARB_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (grant_data || grant_fetch) state_d = odd_word ? ARB_RESP : ARB_LO;
            ARB_LO:   state_d = (sz_q == BYTE_OP) ? ARB_RESP : ARB_HI;
            ARB_HI:   state_d = ARB_RESP;
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Memory strobes are held off while reset is asserted so a transaction
    // being cut off cannot land one more byte write on that edge.
    always_comb begin
        mem_en    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ARB_LO: begin
                mem_en    = reset_n;
                mem_addr  = addr_q;
                mem_wdata = wdata_q[7:0];
            end
            ARB_HI: begin
                mem_en    = reset_n;
                mem_addr  = addr_q + 16'd1;
                mem_wdata = wdata_q[15:8];
            end
            default: ;
        endcase
        mem_we = mem_en && we_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner_q    <= OWN_FETCH;
            addr_q     <= '0;
            wdata_q    <= '0;
            sz_q       <= WORD_OP;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            rdata_lo_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: if (grant_data || grant_fetch) begin
                    owner_q    <= grant_data ? OWN_DATA : OWN_FETCH;
                    addr_q     <= req_addr;
                    wdata_q    <= grant_data ? dt_wdata : '0;
                    sz_q       <= req_sz;
                    we_q       <= grant_data && dt_we;
                    err_q      <= odd_word;
                    rdata_lo_q <= '0;
                end
                ARB_LO: if (!we_q) rdata_lo_q <= mem_rdata;
                default: ;
            endcase
        end
    end

    // Response values are formed on the edge entering RESP so the done
    // pulse and its data come straight from flops.
    assign resp_fire  = (state_d == ARB_RESP) && (state_q != ARB_RESP);
    assign resp_owner = (state_q == ARB_IDLE) ? (grant_data ? OWN_DATA : OWN_FETCH) : owner_q;
    assign resp_err   = (state_q == ARB_IDLE) ? odd_word : err_q;

    always_comb begin
        resp_rdata = '0;
        if (!we_q) begin
            case (state_q)
                ARB_LO:  resp_rdata = {8'h00, mem_rdata};
                ARB_HI:  resp_rdata = {mem_rdata, rdata_lo_q};
                default: resp_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            if_done  <= 1'b0;
            if_rdata <= '0;
            if_err   <= 1'b0;
            dt_done  <= 1'b0;
            dt_rdata <= '0;
            dt_err   <= 1'b0;
        end else begin
            if_done  <= resp_fire && (resp_owner == OWN_FETCH);
            if_rdata <= (resp_fire && (resp_owner == OWN_FETCH)) ? resp_rdata : '0;
            if_err   <= resp_fire && (resp_owner == OWN_FETCH) && resp_err;
            dt_done  <= resp_fire && (resp_owner == OWN_DATA);
            dt_rdata <= (resp_fire && (resp_owner == OWN_DATA)) ? resp_rdata : '0;
            dt_err   <= resp_fire && (resp_owner == OWN_DATA) && resp_err;
        end
    end

`ifdef MEM_TRACE_EN
    always @(posedge clk) begin
        if (reset_n && (state_q == ARB_RESP) && !err_q)
            $display("%0d %06o", access_code(owner_q, we_q), addr_q);
    end
`else
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: vector table through a
// scoreboard, plus priority and reset-during-transaction sequences.
module tb_mem_access_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        if_req, dt_req, if_req1, dt_req1, dt_we, dt_sz;
    logic [15:0] if_addr, dt_addr, dt_wdata;

    logic        if_done0, if_err0, dt_done0, dt_err0, mem_en0, mem_we0;
    logic [15:0] if_rdata0, dt_rdata0, mem_addr0;
    logic [7:0]  mem_wdata0, mem_rdata0;
    logic        if_done1, if_err1, dt_done1, dt_err1, mem_en1, mem_we1;
    logic [15:0] if_rdata1, dt_rdata1, mem_addr1;
    logic [7:0]  mem_wdata1, mem_rdata1;

    logic [7:0] mem0 [0:65535];
    logic [7:0] mem1 [0:65535];

    assign mem_rdata0 = mem0[mem_addr0];
    assign mem_rdata1 = mem1[mem_addr1];
    always @(posedge clk) if (mem_en0 && mem_we0) mem0[mem_addr0] <= mem_wdata0;
    always @(posedge clk) if (mem_en1 && mem_we1) mem1[mem_addr1] <= mem_wdata1;

    mem_access_arbiter #(.DATA_FIRST(1)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done0), .if_rdata(if_rdata0), .if_err(if_err0),
        .dt_req(dt_req), .dt_we(dt_we), .dt_sz(dt_sz), .dt_addr(dt_addr), .dt_wdata(dt_wdata),
        .dt_done(dt_done0), .dt_rdata(dt_rdata0), .dt_err(dt_err0),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata0)
    );

    mem_access_arbiter #(.DATA_FIRST(0)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req1), .if_addr(if_addr), .if_done(if_done1), .if_rdata(if_rdata1), .if_err(if_err1),
        .dt_req(dt_req1), .dt_we(dt_we), .dt_sz(dt_sz), .dt_addr(dt_addr), .dt_wdata(dt_wdata),
        .dt_done(dt_done1), .dt_rdata(dt_rdata1), .dt_err(dt_err1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1)
    );

    typedef struct {
        logic        fetch;
        logic        we;
        logic        sz;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_cyc;
    } vec_t;

    typedef struct {
        logic        fetch;
        logic [15:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    vec_t vecs[12];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one request on dut0 while it is idle and follows it to done.
    task automatic run_vec(input int idx, input vec_t v);
        exp_t        e;
        int          n, cyc;
        bit          got;
        logic [15:0] a0, a1;
        string       tag;
        tag = $sformatf("vec%0d", idx);
        e.fetch = v.fetch; e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat;
        sb0.push_back(e);
        if_addr  = v.addr;
        dt_addr  = v.addr;
        dt_we    = v.we;
        dt_sz    = v.sz;
        dt_wdata = v.wdata;
        if (v.fetch) if_req = 1'b1; else dt_req = 1'b1;
        n = 0; cyc = 0; got = 0; a0 = '0; a1 = '0;
        while (!got && n < 12) begin
            @(posedge clk); #1;
            n++;
            if (mem_en0) begin
                if (cyc == 0) a0 = mem_addr0;
                if (cyc == 1) a1 = mem_addr0;
                cyc++;
            end
            if (if_done0 || dt_done0) begin
                got = 1;
                if_req = 1'b0;
                dt_req = 1'b0;
                if (sb0.size() == 0) begin
                    check({tag, "_unexpected_done"}, 1, 0);
                end else begin
                    e = sb0.pop_front();
                    check({tag, "_owner"}, {if_done0, dt_done0}, {e.fetch, ~e.fetch});
                    check({tag, "_rdata"}, e.fetch ? if_rdata0 : dt_rdata0, e.rdata);
                    check({tag, "_err"}, e.fetch ? if_err0 : dt_err0, e.err);
                    check({tag, "_latency"}, n, e.lat);
                end
            end
        end
        if (!got) begin
            check({tag, "_timeout"}, 0, 1);
            if_req = 1'b0;
            dt_req = 1'b0;
            if (sb0.size() > 0) void'(sb0.pop_front());
        end
        check({tag, "_mem_cycles"}, cyc, v.exp_cyc);
        if (v.exp_cyc >= 1) check({tag, "_addr_lo"}, a0, v.addr);
        if (v.exp_cyc >= 2) check({tag, "_addr_hi"}, a1, v.addr + 16'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic handle_done(input int which, input logic fd, input logic dd,
                               input logic [15:0] fr, input logic [15:0] dr, input int n);
        exp_t e;
        bit   empty;
        empty = (which == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
        if (empty) begin
            check($sformatf("prio%0d_extra_done", which), 1, 0);
        end else begin
            e = (which == 0) ? sb0.pop_front() : sb1.pop_front();
            check($sformatf("prio%0d_owner", which), {fd, dd}, {e.fetch, ~e.fetch});
            check($sformatf("prio%0d_rdata", which), fd ? fr : dr, e.rdata);
            check($sformatf("prio%0d_latency", which), n, e.lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n, dones;

        for (int i = 0; i < 65536; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        mem0[16'o001000] = 8'h05; mem0[16'o001001] = 8'h15;
        mem0[16'o003000] = 8'h11; mem0[16'o003001] = 8'h80;
        mem0[16'o177776] = 8'h34; mem0[16'o177777] = 8'h12;
        mem1[16'o001000] = 8'h05; mem1[16'o001001] = 8'h15;
        mem1[16'o002000] = 8'hEF; mem1[16'o002001] = 8'hBE;

        //          fetch we  sz   addr         wdata     rdata     err lat cyc
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'o001000, 16'h0000, 16'h1505, 1'b0, 3, 2};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'o002000, 16'hBEEF, 16'h0000, 1'b0, 3, 2};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'o002000, 16'h0000, 16'hBEEF, 1'b0, 3, 2};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'o003001, 16'h0000, 16'h0080, 1'b0, 2, 1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'o003001, 16'h0000, 16'h0000, 1'b1, 1, 0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'o001001, 16'h0000, 16'h0000, 1'b1, 1, 0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 16'o003001, 16'h12A5, 16'h0000, 1'b0, 2, 1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'o003000, 16'h0000, 16'h0011, 1'b0, 2, 1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'o003000, 16'h0000, 16'hA511, 1'b0, 3, 2};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'o177776, 16'h0000, 16'h1234, 1'b0, 3, 2};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 16'o177777, 16'h0077, 16'h0000, 1'b0, 2, 1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 16'o177776, 16'h0000, 16'h7734, 1'b0, 3, 2};

        reset_n = 1'b0;
        if_req = 1'b0; dt_req = 1'b0; if_req1 = 1'b0; dt_req1 = 1'b0;
        dt_we = 1'b0; dt_sz = 1'b0; if_addr = '0; dt_addr = '0; dt_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_done", {if_done0, dt_done0, if_err0, dt_err0}, 4'b0000);
        check("reset_rdata", {if_rdata0, dt_rdata0}, 32'h0);
        check("reset_mem", {mem_en0, mem_we0, mem_addr0, mem_wdata0}, 26'h0);
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        check("mem_2000", mem0[16'o002000], 8'hEF);
        check("mem_2001", mem0[16'o002001], 8'hBE);
        check("mem_3000_untouched", mem0[16'o003000], 8'h11);
        check("mem_3001", mem0[16'o003001], 8'hA5);
        check("mem_177776_untouched", mem0[16'o177776], 8'h34);

        // Simultaneous requests: dut0 favours data, dut1 favours fetch.
        if_addr = 16'o001000; dt_addr = 16'o002000; dt_we = 1'b0; dt_sz = 1'b0; dt_wdata = '0;
        e = '{1'b0, 16'hBEEF, 1'b0, 3}; sb0.push_back(e);
        e = '{1'b1, 16'h1505, 1'b0, 7}; sb0.push_back(e);
        e = '{1'b1, 16'h1505, 1'b0, 3}; sb1.push_back(e);
        e = '{1'b0, 16'hBEEF, 1'b0, 7}; sb1.push_back(e);
        if_req = 1'b1; dt_req = 1'b1; if_req1 = 1'b1; dt_req1 = 1'b1;
        n = 0;
        while ((sb0.size() > 0 || sb1.size() > 0) && n < 14) begin
            @(posedge clk); #1;
            n++;
            if (if_done0 || dt_done0) begin
                handle_done(0, if_done0, dt_done0, if_rdata0, dt_rdata0, n);
                if (if_done0) if_req = 1'b0;
                if (dt_done0) dt_req = 1'b0;
            end
            if (if_done1 || dt_done1) begin
                handle_done(1, if_done1, dt_done1, if_rdata1, dt_rdata1, n);
                if (if_done1) if_req1 = 1'b0;
                if (dt_done1) dt_req1 = 1'b0;
            end
        end
        check("prio0_pending", sb0.size(), 0);
        check("prio1_pending", sb1.size(), 0);
        if_req = 1'b0; dt_req = 1'b0; if_req1 = 1'b0; dt_req1 = 1'b0;
        sb0.delete(); sb1.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset asserted during the high byte of a word write.
        dt_addr = 16'o004000; dt_we = 1'b1; dt_sz = 1'b0; dt_wdata = 16'hCAFE;
        dt_req = 1'b1;
        @(posedge clk); #1;
        check("rst_seq_lo", {mem_en0, mem_we0, mem_addr0}, {2'b11, 16'o004000});
        @(posedge clk); #1;
        check("rst_seq_hi", {mem_en0, mem_addr0}, {1'b1, 16'o004001});
        @(negedge clk);
        reset_n = 1'b0;
        dt_req = 1'b0;
        @(posedge clk); #1;
        check("rst_cut_done", {if_done0, dt_done0, if_err0, dt_err0}, 4'b0000);
        check("rst_cut_rdata", {if_rdata0, dt_rdata0}, 32'h0);
        check("rst_cut_mem", {mem_en0, mem_we0, mem_addr0, mem_wdata0}, 26'h0);
        check("rst_cut_lo_written", mem0[16'o004000], 8'hFE);
        check("rst_cut_hi_untouched", mem0[16'o004001], 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (dt_done0 || if_done0 || mem_en0) dones++;
        end
        check("rst_no_late_activity", dones, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
